wb_vga_pattern_src: RTL and testbench

//  Read-only Wishbone slave that sources frame data for the VGA fetch master (wb_vga_sword wbm port).

---
 rtl/wb_vga_pattern_src_pkg.sv | 36 +++
 rtl/wb_burst_addr_gen.sv | 42 ++++
 rtl/wb_vga_pattern_src.sv | 186 ++++++++++++++++++
 tb/tb_wb_vga_pattern_src.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_vga_pattern_src_pkg.sv
// Shared constants, FSM state type and pixel-pattern helper for the
// Wishbone VGA pattern source and its burst address generator.
package wb_vga_pattern_src_pkg;

   // Wishbone cycle type identifiers
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   // Wishbone burst type identifiers
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      ERR   = 2'd3
   } state_t;

   // Pixel word derived from a word address.
   // pat=1: 16-bit word address replicated; pat=0: fixed colour tag plus low address byte.
   function automatic logic [31:0] pix_word(input logic [29:0] addr, input logic pat);
      logic [31:0] word;
      if (pat) begin
         word = {addr[15:0], addr[15:0]};
      end else begin
         word = {24'h072007, addr[7:0]};
      end
      return word;
   endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational next-beat address for Wishbone incrementing bursts.
// Linear bursts increment the full word address; wrap-N bursts increment
// only the low log2(N) bits and keep everything above them.
module wb_burst_addr_gen
   import wb_vga_pattern_src_pkg::*;
(
   input  logic [29:0] addr,
   input  logic [1:0]  bte,
   output logic [29:0] addr_next
);

   logic [29:0] addr_inc;
   logic [3:0]  low_mask;
   logic        linear;

   assign addr_inc = addr + 30'd1;
   assign linear   = (bte == BTE_LINEAR);

   // Select which of the low four bits take the incremented value
   always_comb begin
      low_mask = 4'b1111;
      case (bte)
         BTE_LINEAR: low_mask = 4'b1111;
         BTE_WRAP4:  low_mask = 4'b0011;
         BTE_WRAP8:  low_mask = 4'b0111;
         BTE_WRAP16: low_mask = 4'b1111;
         default:    low_mask = 4'b1111;
      endcase
   end

   // Per-bit merge: wrap region bits come from the increment, the rest stay
   generate
      for (genvar gi = 0; gi < 30; gi++) begin : g_bit
         if (gi < 4) begin : g_low
            assign addr_next[gi] = low_mask[gi] ? addr_inc[gi] : addr[gi];
         end else begin : g_high
            assign addr_next[gi] = linear ? addr_inc[gi] : addr[gi];
         end
      end
   endgenerate

endmodule

// File: rtl/wb_vga_pattern_src.sv
// Read-only Wishbone slave returning address-derived pixel words for video
// bring-up. Supports classic and incrementing bursts with programmable wait
// states, rejects writes with an error pulse and keeps saturating beat/cycle
// statistics for a debug display.
module wb_vga_pattern_src
   import wb_vga_pattern_src_pkg::*;
#(
   parameter int unsigned WAIT_FIRST = 2,
   parameter int unsigned WAIT_BEAT  = 0,
   parameter int unsigned STAT_BITS  = 16
) (
   input  logic                 clk_bus,
   input  logic                 rst,
   input  logic [7:0]           mode,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic [29:0]          wbs_addr_i,
   input  logic [2:0]           wbs_cti_i,
   input  logic [1:0]           wbs_bte_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic                 wbs_we_i,
   input  logic [31:0]          wbs_data_i,
   output logic [31:0]          wbs_data_o,
   output logic                 wbs_ack_o,
   output logic                 wbs_err_o,
   output logic [STAT_BITS-1:0] stat_beats,
   output logic [STAT_BITS-1:0] stat_bursts
);

   // One counter serves both the first-beat and the inter-beat wait
   localparam int unsigned CNT_MAX = (WAIT_FIRST > WAIT_BEAT) ? WAIT_FIRST : WAIT_BEAT;
   localparam int          CNT_W   = $clog2(CNT_MAX + 2);
   localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(WAIT_FIRST - 1);
   localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(WAIT_BEAT);

   state_t                state_reg,  state_next;
   logic [29:0]           addr_reg,   addr_next;
   logic                  pat_reg,    pat_next;
   logic [1:0]            bte_reg,    bte_next;
   logic [CNT_W-1:0]      cnt_reg,    cnt_next;
   logic                  ack_reg,    ack_next;
   logic                  err_reg,    err_next;
   logic [31:0]           data_reg,   data_next;
   logic [STAT_BITS-1:0]  beats_reg,  beats_next;
   logic [STAT_BITS-1:0]  bursts_reg, bursts_next;

   logic        take_beat;
   logic [29:0] beat_addr;
   logic [1:0]  beat_bte;
   logic        beat_pat;
   logic [29:0] addr_inc;

   // Byte selects, write data and the non-pattern mode bits play no part in reads
   logic unused_inputs;
   assign unused_inputs = ^{wbs_sel_i, wbs_data_i, mode[6:0]};

   // A zero-wait first beat is acked straight out of IDLE using the bus
   // address; every other beat uses the latched burst address.
   assign beat_addr = (state_reg == IDLE) ? wbs_addr_i : addr_reg;
   assign beat_bte  = (state_reg == IDLE) ? wbs_bte_i  : bte_reg;
   assign beat_pat  = (state_reg == IDLE) ? mode[7]    : pat_reg;

   wb_burst_addr_gen u_addr_gen (
      .addr      (beat_addr),
      .bte       (beat_bte),
      .addr_next (addr_inc)
   );

   // Next-state, wait counting, ack generation and statistics update
   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      pat_next    = pat_reg;
      bte_next    = bte_reg;
      cnt_next    = cnt_reg;
      ack_next    = 1'b0;
      err_next    = 1'b0;
      data_next   = '0;
      beats_next  = beats_reg;
      bursts_next = bursts_reg;
      take_beat   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               if (wbs_we_i) begin
                  state_next = ERR;
                  err_next   = 1'b1;
               end else begin
                  addr_next = wbs_addr_i;
                  pat_next  = mode[7];
                  bte_next  = wbs_bte_i;
                  cnt_next  = '0;
                  if (WAIT_FIRST == 0) begin
                     take_beat = 1'b1;
                  end else begin
                     state_next = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (!wbs_cyc_i) begin
               state_next = IDLE;
            end else if (cnt_reg == FIRST_LAST) begin
               take_beat = wbs_stb_i;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         BURST: begin
            // A stalled master (stb low) freezes both address and wait count
            if (!wbs_cyc_i) begin
               state_next = IDLE;
            end else if (wbs_stb_i) begin
               if (cnt_reg == BEAT_LAST) begin
                  take_beat = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         ERR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (take_beat) begin
         ack_next   = 1'b1;
         data_next  = pix_word(beat_addr, beat_pat);
         cnt_next   = '0;
         beats_next = (beats_reg == '1) ? beats_reg : beats_reg + STAT_BITS'(1);
         case (wbs_cti_i)
            CTI_INCR: begin
               state_next = BURST;
               addr_next  = addr_inc;
            end
            CTI_CLASSIC, CTI_CONST, CTI_END: begin
               state_next  = IDLE;
               bursts_next = (bursts_reg == '1) ? bursts_reg : bursts_reg + STAT_BITS'(1);
            end
            default: begin
               state_next  = IDLE;
               bursts_next = (bursts_reg == '1) ? bursts_reg : bursts_reg + STAT_BITS'(1);
            end
         endcase
      end
   end

   // Register all state; reset overrides any bus activity
   always_ff @(posedge clk_bus) begin
      if (rst) begin
         state_reg  <= IDLE;
         addr_reg   <= '0;
         pat_reg    <= 1'b0;
         bte_reg    <= BTE_LINEAR;
         cnt_reg    <= '0;
         ack_reg    <= 1'b0;
         err_reg    <= 1'b0;
         data_reg   <= '0;
         beats_reg  <= '0;
         bursts_reg <= '0;
      end else begin
         state_reg  <= state_next;
         addr_reg   <= addr_next;
         pat_reg    <= pat_next;
         bte_reg    <= bte_next;
         cnt_reg    <= cnt_next;
         ack_reg    <= ack_next;
         err_reg    <= err_next;
         data_reg   <= data_next;
         beats_reg  <= beats_next;
         bursts_reg <= bursts_next;
      end
   end

   assign wbs_data_o  = data_reg;
   assign wbs_ack_o   = ack_reg;
   assign wbs_err_o   = err_reg;
   assign stat_beats  = beats_reg;
   assign stat_bursts = bursts_reg;

endmodule

// File: tb/tb_wb_vga_pattern_src.sv
// Directed bench for wb_vga_pattern_src: the stimulus process pushes the
// expected response of every beat into a scoreboard queue, a monitor pops
// and compares whenever the slave acks or errors.
module tb_wb_vga_pattern_src;

   logic        clk_bus = 1'b0;
   logic        rst;
   logic [7:0]  mode;
   logic        cyc, stb, we;
   logic [29:0] addr;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack, err;
   logic [15:0] stat_beats, stat_bursts;

   typedef struct packed {
      logic        is_err;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   fails  = 0;
   int   first_lat, last_lat;
   int   exp_beats = 0, exp_bursts = 0;

   always #5 clk_bus = ~clk_bus;

   wb_vga_pattern_src #(
      .WAIT_FIRST (2),
      .WAIT_BEAT  (0),
      .STAT_BITS  (16)
   ) dut (
      .clk_bus     (clk_bus),
      .rst         (rst),
      .mode        (mode),
      .wbs_cyc_i   (cyc),
      .wbs_stb_i   (stb),
      .wbs_addr_i  (addr),
      .wbs_cti_i   (cti),
      .wbs_bte_i   (bte),
      .wbs_sel_i   (sel),
      .wbs_we_i    (we),
      .wbs_data_i  (wdata),
      .wbs_data_o  (rdata),
      .wbs_ack_o   (ack),
      .wbs_err_o   (err),
      .stat_beats  (stat_beats),
      .stat_bursts (stat_bursts)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic check_stats(input string name);
      check({name, "_beats"},  {16'd0, stat_beats},  32'(exp_beats));
      check({name, "_bursts"}, {16'd0, stat_bursts}, 32'(exp_bursts));
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge
   always @(negedge clk_bus) begin
      if (ack || err) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_resp ack=%0b err=%0b data=%h required=no response", ack, err, rdata);
         end else begin
            mon_e = exp_q.pop_front();
            if ((ack == err) || (mon_e.is_err != err) || (rdata !== mon_e.data)) begin
               fails++;
               $display("FAIL resp actual ack=%0b err=%0b data=%h required err=%0b data=%h",
                        ack, err, rdata, mon_e.is_err, mon_e.data);
            end else begin
               $display("resp ok: %s data=%h", err ? "err" : "ack", rdata);
            end
         end
      end else if (!rst) begin
         checks++;
         if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL idle_data actual=%h required=00000000", rdata);
         end
      end
   end

   // Drive one read cycle of nbeats (1 = classic); optional 2-cycle stb stall after beat stall_after
   task automatic run_read(input logic [29:0] a, input logic [1:0] b, input logic [7:0] md,
                           input int nbeats, input int stall_after,
                           output int lat_first, output int lat_last);
      int done;
      int edges;
      done      = 0;
      edges     = 0;
      lat_first = -1;
      lat_last  = -1;
      cyc  = 1'b1;
      stb  = 1'b1;
      we   = 1'b0;
      addr = a;
      bte  = b;
      mode = md;
      cti  = (nbeats > 1) ? 3'b010 : 3'b000;
      while (done < nbeats && edges < 200) begin
         @(posedge clk_bus);
         #1;
         edges++;
         if (ack) begin
            if (lat_first < 0) lat_first = edges;
            lat_last = edges;
            done++;
            addr = a + 30'(done);
            cti  = (done == nbeats - 1) ? 3'b111 : 3'b010;
            if (done == stall_after && done < nbeats) begin
               stb = 1'b0;
               repeat (2) begin
                  @(posedge clk_bus);
                  #1;
                  edges++;
                  check("stall_no_ack", {31'd0, ack}, 32'd0);
               end
               stb = 1'b1;
            end
         end
      end
      check("beats_done", 32'(done), 32'(nbeats));
      cyc = 1'b0;
      stb = 1'b0;
      cti = 3'b000;
      $display("read addr=%h bte=%0d mode=%h beats=%0d first=%0d last=%0d",
               a, b, md, done, lat_first, lat_last);
   endtask

   initial begin
      int seen;
      int edges;
      rst   = 1'b1;
      mode  = 8'h00;
      cyc   = 1'b0;
      stb   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      cti   = 3'b000;
      bte   = 2'b00;
      sel   = 4'hF;
      wdata = 32'hDEADBEEF;
      repeat (3) @(posedge clk_bus);
      #1;
      check("por_ack", {31'd0, ack}, 32'd0);
      check("por_err", {31'd0, err}, 32'd0);
      check("por_data", rdata, 32'd0);
      check_stats("por");
      rst = 1'b0;

      // Reset during beat 3 of a wrap8 burst starting at 0x26
      exp_q.push_back('{1'b0, 32'h00260026});
      exp_q.push_back('{1'b0, 32'h00270027});
      cyc = 1'b1; stb = 1'b1; addr = 30'h26; bte = 2'b10; mode = 8'h80; cti = 3'b010;
      seen  = 0;
      edges = 0;
      while (seen < 2 && edges < 50) begin
         @(posedge clk_bus);
         #1;
         edges++;
         if (ack) seen++;
      end
      check("rst_pre_beats", 32'(seen), 32'd2);
      check("rst_pre_stat", {16'd0, stat_beats}, 32'd2);
      rst = 1'b1;
      @(posedge clk_bus);
      #1;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_data", rdata, 32'd0);
      check_stats("rst");
      $display("reset mid-burst applied");
      cyc = 1'b0; stb = 1'b0; cti = 3'b000;
      @(posedge clk_bus);
      #1;
      rst = 1'b0;

      // Classic read
      exp_q.push_back('{1'b0, 32'h07200710});
      run_read(30'h10, 2'b00, 8'h00, 1, 0, first_lat, last_lat);
      check("classic_lat", 32'(first_lat), 32'd3);
      exp_beats = 1; exp_bursts = 1;
      check_stats("classic");

      // Linear incrementing burst
      exp_q.push_back('{1'b0, 32'h01000100});
      exp_q.push_back('{1'b0, 32'h01010101});
      exp_q.push_back('{1'b0, 32'h01020102});
      exp_q.push_back('{1'b0, 32'h01030103});
      run_read(30'h100, 2'b00, 8'h80, 4, 0, first_lat, last_lat);
      check("linear_first_lat", 32'(first_lat), 32'd3);
      check("linear_span", 32'(last_lat - first_lat), 32'd3);
      exp_beats = 5; exp_bursts = 2;
      check_stats("linear");

      // Wrap4 from 6 -> 6,7,4,5
      exp_q.push_back('{1'b0, 32'h00060006});
      exp_q.push_back('{1'b0, 32'h00070007});
      exp_q.push_back('{1'b0, 32'h00040004});
      exp_q.push_back('{1'b0, 32'h00050005});
      run_read(30'h6, 2'b01, 8'h80, 4, 0, first_lat, last_lat);
      exp_beats = 9; exp_bursts = 3;
      check_stats("wrap4");

      // Wrap16 from 0x1E -> 1E,1F,10,11
      exp_q.push_back('{1'b0, 32'h0720071E});
      exp_q.push_back('{1'b0, 32'h0720071F});
      exp_q.push_back('{1'b0, 32'h07200710});
      exp_q.push_back('{1'b0, 32'h07200711});
      run_read(30'h1E, 2'b11, 8'h00, 4, 0, first_lat, last_lat);
      exp_beats = 13; exp_bursts = 4;
      check_stats("wrap16");

      // Master stall: stb low 2 cycles after beat 2, burst resumes at the held address
      exp_q.push_back('{1'b0, 32'h07200740});
      exp_q.push_back('{1'b0, 32'h07200741});
      exp_q.push_back('{1'b0, 32'h07200742});
      exp_q.push_back('{1'b0, 32'h07200743});
      run_read(30'h40, 2'b00, 8'h00, 4, 2, first_lat, last_lat);
      check("stall_span", 32'(last_lat - first_lat), 32'd5);
      exp_beats = 17; exp_bursts = 5;
      check_stats("stall");

      // Write rejected with a one-cycle error pulse
      exp_q.push_back('{1'b1, 32'h00000000});
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h33; cti = 3'b000; bte = 2'b00;
      @(posedge clk_bus);
      #1;
      check("write_err", {31'd0, err}, 32'd1);
      check("write_ack", {31'd0, ack}, 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk_bus);
      #1;
      check("write_err_pulse", {31'd0, err}, 32'd0);
      check_stats("write");
      $display("write rejected");

      // Cycle dropped during the first-beat wait: no ack, no cycle counted
      cyc = 1'b1; stb = 1'b1; addr = 30'h50; mode = 8'h00;
      @(posedge clk_bus);
      #1;
      cyc = 1'b0; stb = 1'b0;
      repeat (4) begin
         @(posedge clk_bus);
         #1;
         check("abort_no_ack", {31'd0, ack}, 32'd0);
      end
      check_stats("abort");
      $display("cycle aborted in wait");

      // Slave back in IDLE after the abort
      exp_q.push_back('{1'b0, 32'h07200755});
      run_read(30'h55, 2'b00, 8'h00, 1, 0, first_lat, last_lat);
      check("post_abort_lat", 32'(first_lat), 32'd3);
      exp_beats = 18; exp_bursts = 6;
      check_stats("post_abort");

      repeat (5) @(posedge clk_bus);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
